// File: rtl/microcode_sequencer_if.sv
// Handshake, ROM-field and status bundle between the microcode sequencer and its
// surroundings (decode stage, microcode ROM, bus unit and interrupt controller).
interface microcode_sequencer_if #(
  parameter int ADDR_W = 7
);
  logic              instr_valid;
  logic [ADDR_W-1:0] instr_entry;
  logic              instr_ready;
  logic [ADDR_W-1:0] uop_addr;
  logic              exec_en;
  logic              ctrl_last;
  logic              ctrl_mem_req;
  logic              ctrl_cond_en;
  logic              ctrl_halt;
  logic              cond_met;
  logic              mem_ready;
  logic              irq_pending;
  logic              irq_ack;
  logic              instr_done;
  logic              uop_overrun;

  modport master (
    output instr_valid, instr_entry, ctrl_last, ctrl_mem_req, ctrl_cond_en,
           ctrl_halt, cond_met, mem_ready, irq_pending,
    input  instr_ready, uop_addr, exec_en, irq_ack, instr_done, uop_overrun
  );

  modport slave (
    input  instr_valid, instr_entry, ctrl_last, ctrl_mem_req, ctrl_cond_en,
           ctrl_halt, cond_met, mem_ready, irq_pending,
    output instr_ready, uop_addr, exec_en, irq_ack, instr_done, uop_overrun
  );
endinterface

// File: rtl/microcode_sequencer.sv
// Walks the microcode ROM through each instruction's micro-ops, gating commit on
// bus stalls and dispatching interrupts only at instruction boundaries.
module microcode_sequencer #(
  parameter int              ADDR_W    = 7,
  parameter logic [ADDR_W-1:0] IRQ_ENTRY = 7'h78,
  parameter int              MAX_UOPS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  microcode_sequencer_if.slave  bus
);
  localparam int STEP_W = (MAX_UOPS > 1) ? $clog2(MAX_UOPS) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, HALT} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] uop_addr_q;
  logic [STEP_W-1:0] step_q;
  logic              irq_ack_q;
  logic              overrun_q;

  logic commit;
  logic at_limit;
  logic natural_retire;
  logic halt_now;
  logic retire;
  logic overrun_hit;
  logic boundary;
  logic take_irq;
  logic take_instr;

  assign commit         = (state_q == EXEC) && !(bus.ctrl_mem_req && !bus.mem_ready);
  assign at_limit       = (step_q == STEP_W'(MAX_UOPS - 1));
  assign natural_retire = bus.ctrl_last || (bus.ctrl_cond_en && !bus.cond_met);
  assign halt_now       = commit && bus.ctrl_halt;
  // HALT wins over the step limit; otherwise the limit forces a retire.
  assign retire         = commit && !bus.ctrl_halt && (natural_retire || at_limit);
  assign overrun_hit    = commit && !bus.ctrl_halt && !natural_retire && at_limit;

  // Interrupts may enter at any instruction boundary, including out of HALT.
  assign boundary   = (state_q == IDLE) || retire;
  assign take_irq   = bus.irq_pending && (boundary || (state_q == HALT));
  assign take_instr = bus.instr_valid && bus.instr_ready;

  assign bus.instr_ready = boundary && !bus.irq_pending;
  assign bus.uop_addr    = uop_addr_q;
  assign bus.exec_en     = commit;
  assign bus.instr_done  = halt_now || retire;
  assign bus.irq_ack     = irq_ack_q;
  assign bus.uop_overrun = overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      uop_addr_q <= '0;
      step_q     <= '0;
      irq_ack_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      irq_ack_q <= 1'b0;
      if (overrun_hit) overrun_q <= 1'b1;

      if (take_irq) begin
        state_q    <= EXEC;
        uop_addr_q <= IRQ_ENTRY;
        step_q     <= '0;
        irq_ack_q  <= 1'b1;
      end else if (take_instr) begin
        state_q    <= EXEC;
        uop_addr_q <= bus.instr_entry;
        step_q     <= '0;
      end else if (halt_now) begin
        state_q <= HALT;
      end else if (retire) begin
        state_q <= IDLE;
      end else if (commit) begin
        uop_addr_q <= uop_addr_q + 1'b1;
        step_q     <= step_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: a small ROM model answers uop_addr with
// per-address sequencing fields; each scenario task checks cycle by cycle.
module tb_microcode_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  microcode_sequencer_if #(.ADDR_W(7)) bus ();

  microcode_sequencer #(.ADDR_W(7), .IRQ_ENTRY(7'h78), .MAX_UOPS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic rom_last [128];
  logic rom_mem  [128];
  logic rom_cond [128];
  logic rom_halt [128];

  always_comb begin
    bus.ctrl_last    = rom_last[bus.uop_addr];
    bus.ctrl_mem_req = rom_mem[bus.uop_addr];
    bus.ctrl_cond_en = rom_cond[bus.uop_addr];
    bus.ctrl_halt    = rom_halt[bus.uop_addr];
  end

  task automatic rom_clear();
    for (int a = 0; a < 128; a++) begin
      rom_last[a] = 1'b0; rom_mem[a] = 1'b0; rom_cond[a] = 1'b0; rom_halt[a] = 1'b0;
    end
    rom_last[7'h78] = 1'b1;
  endtask

  // Advance to the next falling edge, where inputs are driven and outputs sampled.
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rom_clear();
    bus.instr_valid = 1'b0; bus.instr_entry = '0; bus.cond_met = 1'b0;
    bus.mem_ready = 1'b1; bus.irq_pending = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    settle();
    total++; if (bus.uop_addr !== 7'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", bus.uop_addr); end
    total++; if (bus.exec_en !== 1'b0) begin bad++; $display("FAIL reset_exec got=%b exp=0", bus.exec_en); end
    total++; if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.instr_ready); end
    total++; if (bus.uop_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", bus.uop_overrun); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    rom_clear();
    rom_last[7'h12] = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b1; bus.instr_entry = 7'h10;
    settle();
    total++; if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL basic_accept got=%b exp=1", bus.instr_ready); end
    next_cycle();
    bus.instr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      logic [6:0] exp_a;
      exp_a = 7'h10 + 7'(i);
      settle();
      total++; if (bus.uop_addr !== exp_a || bus.exec_en !== 1'b1) begin
        bad++; $display("FAIL basic_addr%0d got=%h/%b exp=%h/1", i, bus.uop_addr, bus.exec_en, exp_a); end
      total++; if (bus.instr_done !== (i == 2)) begin
        bad++; $display("FAIL basic_done%0d got=%b exp=%b", i, bus.instr_done, (i == 2)); end
      next_cycle();
    end
    settle();
    total++; if (bus.exec_en !== 1'b0 || bus.instr_ready !== 1'b1) begin
      bad++; $display("FAIL basic_idle exec=%b ready=%b exp=0/1", bus.exec_en, bus.instr_ready); end
  endtask

  task automatic test_stall();
    rom_clear();
    rom_last[7'h12] = 1'b1;
    rom_mem[7'h11]  = 1'b1;
    bus.instr_valid = 1'b1; bus.instr_entry = 7'h10;
    next_cycle();
    bus.instr_valid = 1'b0;
    next_cycle();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      total++; if (bus.uop_addr !== 7'h11 || bus.exec_en !== 1'b0) begin
        bad++; $display("FAIL stall_hold%0d got=%h/%b exp=11/0", i, bus.uop_addr, bus.exec_en); end
      next_cycle();
    end
    bus.mem_ready = 1'b1;
    settle();
    total++; if (bus.uop_addr !== 7'h11 || bus.exec_en !== 1'b1) begin
      bad++; $display("FAIL stall_release got=%h/%b exp=11/1", bus.uop_addr, bus.exec_en); end
    next_cycle();
    settle();
    total++; if (bus.uop_addr !== 7'h12 || bus.instr_done !== 1'b1) begin
      bad++; $display("FAIL stall_advance got=%h/%b exp=12/1", bus.uop_addr, bus.instr_done); end
    next_cycle();
  endtask

  task automatic test_cond_exit();
    rom_clear();
    rom_cond[7'h20] = 1'b1;
    rom_last[7'h22] = 1'b1;
    bus.cond_met = 1'b0;
    bus.instr_valid = 1'b1; bus.instr_entry = 7'h20;
    next_cycle();
    bus.instr_valid = 1'b0;
    settle();
    total++; if (bus.uop_addr !== 7'h20 || bus.instr_done !== 1'b1) begin
      bad++; $display("FAIL cond_exit got=%h/%b exp=20/1", bus.uop_addr, bus.instr_done); end
    next_cycle();
    settle();
    total++; if (bus.uop_addr !== 7'h20 || bus.exec_en !== 1'b0) begin
      bad++; $display("FAIL cond_skip got=%h/%b exp=20/0", bus.uop_addr, bus.exec_en); end
    bus.cond_met = 1'b1;
    bus.instr_valid = 1'b1; bus.instr_entry = 7'h20;
    next_cycle();
    bus.instr_valid = 1'b0;
    settle();
    total++; if (bus.instr_done !== 1'b0) begin
      bad++; $display("FAIL cond_met_done got=%b exp=0", bus.instr_done); end
    next_cycle();
    settle();
    total++; if (bus.uop_addr !== 7'h21 || bus.exec_en !== 1'b1) begin
      bad++; $display("FAIL cond_met_next got=%h/%b exp=21/1", bus.uop_addr, bus.exec_en); end
    repeat (2) next_cycle();
    bus.cond_met = 1'b0;
  endtask

  task automatic test_irq_boundary();
    rom_clear();
    rom_last[7'h12] = 1'b1;
    rom_last[7'h30] = 1'b1;
    bus.instr_valid = 1'b1; bus.instr_entry = 7'h10;
    next_cycle();
    bus.instr_valid = 1'b0;
    repeat (2) next_cycle();
    bus.irq_pending = 1'b1; bus.instr_valid = 1'b1; bus.instr_entry = 7'h30;
    settle();
    total++; if (bus.uop_addr !== 7'h12 || bus.instr_done !== 1'b1 || bus.instr_ready !== 1'b0) begin
      bad++; $display("FAIL irq_retire addr=%h done=%b ready=%b exp=12/1/0", bus.uop_addr, bus.instr_done, bus.instr_ready); end
    next_cycle();
    bus.irq_pending = 1'b0;
    settle();
    total++; if (bus.uop_addr !== 7'h78 || bus.irq_ack !== 1'b1) begin
      bad++; $display("FAIL irq_dispatch got=%h/%b exp=78/1", bus.uop_addr, bus.irq_ack); end
    total++; if (bus.instr_done !== 1'b1 || bus.instr_ready !== 1'b1) begin
      bad++; $display("FAIL irq_seq_done done=%b ready=%b exp=1/1", bus.instr_done, bus.instr_ready); end
    next_cycle();
    bus.instr_valid = 1'b0;
    settle();
    total++; if (bus.uop_addr !== 7'h30 || bus.irq_ack !== 1'b0 || bus.exec_en !== 1'b1) begin
      bad++; $display("FAIL irq_b2b addr=%h ack=%b exec=%b exp=30/0/1", bus.uop_addr, bus.irq_ack, bus.exec_en); end
    next_cycle();
    settle();
    total++; if (bus.exec_en !== 1'b0) begin
      bad++; $display("FAIL irq_idle exec=%b exp=0", bus.exec_en); end
  endtask

  task automatic test_halt();
    rom_clear();
    rom_halt[7'h50] = 1'b1;
    bus.instr_valid = 1'b1; bus.instr_entry = 7'h50;
    next_cycle();
    settle();
    total++; if (bus.uop_addr !== 7'h50 || bus.instr_done !== 1'b1 || bus.exec_en !== 1'b1) begin
      bad++; $display("FAIL halt_enter addr=%h done=%b exec=%b exp=50/1/1", bus.uop_addr, bus.instr_done, bus.exec_en); end
    bus.instr_entry = 7'h10;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      settle();
      total++; if (bus.uop_addr !== 7'h50 || bus.exec_en !== 1'b0 || bus.instr_ready !== 1'b0) begin
        bad++; $display("FAIL halt_hold%0d addr=%h exec=%b ready=%b exp=50/0/0", i, bus.uop_addr, bus.exec_en, bus.instr_ready); end
    end
    bus.instr_valid = 1'b0; bus.irq_pending = 1'b1;
    next_cycle();
    bus.irq_pending = 1'b0;
    settle();
    total++; if (bus.uop_addr !== 7'h78 || bus.irq_ack !== 1'b1) begin
      bad++; $display("FAIL halt_irq got=%h/%b exp=78/1", bus.uop_addr, bus.irq_ack); end
    next_cycle();
  endtask

  task automatic test_overrun();
    rom_clear();
    bus.instr_valid = 1'b1; bus.instr_entry = 7'h40;
    next_cycle();
    bus.instr_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [6:0] exp_a;
      exp_a = 7'h40 + 7'(i);
      settle();
      total++; if (bus.uop_addr !== exp_a || bus.instr_done !== (i == 7) || bus.uop_overrun !== 1'b0) begin
        bad++; $display("FAIL ovr_step%0d addr=%h done=%b ovr=%b exp=%h/%b/0", i, bus.uop_addr, bus.instr_done, bus.uop_overrun, exp_a, (i == 7)); end
      next_cycle();
    end
    settle();
    total++; if (bus.uop_overrun !== 1'b1 || bus.exec_en !== 1'b0) begin
      bad++; $display("FAIL ovr_set ovr=%b exec=%b exp=1/0", bus.uop_overrun, bus.exec_en); end
    rom_last[7'h60] = 1'b1;
    bus.instr_valid = 1'b1; bus.instr_entry = 7'h5e;
    next_cycle();
    bus.instr_valid = 1'b0;
    next_cycle();
    settle();
    total++; if (bus.uop_overrun !== 1'b1 || bus.uop_addr !== 7'h5f) begin
      bad++; $display("FAIL ovr_sticky ovr=%b addr=%h exp=1/5f", bus.uop_overrun, bus.uop_addr); end
    rst_n = 1'b0;
    settle();
    total++; if (bus.uop_addr !== 7'h00 || bus.exec_en !== 1'b0 || bus.instr_done !== 1'b0 ||
                 bus.irq_ack !== 1'b0 || bus.uop_overrun !== 1'b0 || bus.instr_ready !== 1'b1) begin
      bad++; $display("FAIL async_reset addr=%h exec=%b done=%b ack=%b ovr=%b ready=%b exp=00/0/0/0/0/1",
                      bus.uop_addr, bus.exec_en, bus.instr_done, bus.irq_ack, bus.uop_overrun, bus.instr_ready); end
    next_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_cond_exit();
    test_irq_boundary();
    test_halt();
    test_overrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
